// File: rtl/act_quant_pipe.sv
// act_quant_pipe: two-stage requantisation (rounding shift + activation, then signed saturation) with valid/ready flow.
// Optional saturation counter is built when ACT_QUANT_SAT_CNT_EN is defined; otherwise sat_count is tied to zero.
module act_quant_pipe #(
    parameter int LANES       = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int PSUM_WIDTH  = 19,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          cfg_load,
    input  logic [1:0]                    cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic [DATA_WIDTH-1:0]         cfg_cap,
    input  logic [2:0]                    cfg_leak_shift,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*PSUM_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic [15:0]                   sat_count
);
    localparam int RW = PSUM_WIDTH + 1;
    localparam logic signed [RW-1:0] MAX_R = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_R = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                     state_r, state_nxt_s;
    logic [1:0]                 mode_r, mode_s;
    logic [SHIFT_WIDTH-1:0]     shift_r, shift_s;
    logic [DATA_WIDTH-1:0]      cap_r, cap_s;
    logic [2:0]                 leak_r, leak_s;
    logic                       cfg_take_s, accept_s, fire_s, s1_adv_s, s2_adv_s;
    logic                       s1_valid_r, s1_last_r, s2_valid_r, s2_last_r;
    logic [LANES*RW-1:0]        s1_act_s, s1_data_r;
    logic [LANES*DATA_WIDTH-1:0] s2_dat_s, s2_data_r;
    logic [LANES-1:0]           s2_sat_s, s2_sat_r;

    // Rounding arithmetic shift followed by the selected activation; cap is clamped to the positive range.
    function automatic logic signed [RW-1:0] act_lane(input logic signed [PSUM_WIDTH-1:0] x,
                                                     input logic [1:0] mode,
                                                     input logic [SHIFT_WIDTH-1:0] sh,
                                                     input logic [DATA_WIDTH-1:0] cap,
                                                     input logic [2:0] leak);
        logic signed [RW-1:0] xe, rnd, r, cap_e, res;
        xe = {x[PSUM_WIDTH-1], x};
        if (sh != '0) rnd = {{(RW-1){1'b0}}, 1'b1} << (sh - 1'b1);
        else          rnd = '0;
        r = (xe + rnd) >>> sh;
        if (cap[DATA_WIDTH-1]) cap_e = MAX_R;
        else                   cap_e = {{(RW-DATA_WIDTH){1'b0}}, cap};
        case (mode)
            2'd0: res = r;
            2'd1: res = r[RW-1] ? '0 : r;
            2'd2: res = r[RW-1] ? '0 : ((r > cap_e) ? cap_e : r);
            2'd3: res = r[RW-1] ? (r >>> leak) : r;
            default: res = r;
        endcase
        return res;
    endfunction

    // Signed saturation to the output width; MSB of the result is the clip flag.
    function automatic logic [DATA_WIDTH:0] sat_lane(input logic signed [RW-1:0] v);
        logic [DATA_WIDTH:0] res;
        if (v > MAX_R)      res = {1'b1, MAX_R[DATA_WIDTH-1:0]};
        else if (v < MIN_R) res = {1'b1, MIN_R[DATA_WIDTH-1:0]};
        else                res = {1'b0, v[DATA_WIDTH-1:0]};
        return res;
    endfunction

    assign cfg_take_s = cfg_load & (state_r == IDLE);
    assign s2_adv_s   = ~s2_valid_r | out_ready;
    assign s1_adv_s   = ~s1_valid_r | s2_adv_s;
    assign in_ready   = s1_adv_s & (state_r != DRAIN);
    assign accept_s   = in_valid & in_ready;
    assign fire_s     = s2_valid_r & out_ready;
    assign out_valid  = s2_valid_r;
    assign out_data   = s2_data_r;
    assign out_last   = s2_last_r;
    assign busy       = (state_r != IDLE);

    // A config load in IDLE applies to a beat accepted on the same edge.
    always_comb begin
        if (cfg_take_s) begin
            mode_s  = cfg_mode;
            shift_s = cfg_shift;
            cap_s   = cfg_cap;
            leak_s  = cfg_leak_shift;
        end else begin
            mode_s  = mode_r;
            shift_s = shift_r;
            cap_s   = cap_r;
            leak_s  = leak_r;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign s1_act_s[i*RW +: RW] = act_lane(in_data[i*PSUM_WIDTH +: PSUM_WIDTH], mode_s, shift_s, cap_s, leak_s);
        assign {s2_sat_s[i], s2_dat_s[i*DATA_WIDTH +: DATA_WIDTH]} = sat_lane(s1_data_r[i*RW +: RW]);
    end

    // Layer frame state machine: next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (accept_s) state_nxt_s = in_last ? DRAIN : RUN; else state_nxt_s = IDLE;
            RUN:     if (accept_s && in_last) state_nxt_s = DRAIN; else state_nxt_s = RUN;
            DRAIN:   if (fire_s && s2_last_r) state_nxt_s = IDLE; else state_nxt_s = DRAIN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State and layer configuration registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
            mode_r  <= 2'd0;
            shift_r <= '0;
            cap_r   <= '0;
            leak_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (cfg_take_s) begin
                mode_r  <= cfg_mode;
                shift_r <= cfg_shift;
                cap_r   <= cfg_cap;
                leak_r  <= cfg_leak_shift;
            end
        end
    end

    // Two pipeline stages; each only moves when the stage ahead can take its contents.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_data_r  <= '0;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_data_r  <= '0;
            s2_sat_r   <= '0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= accept_s;
                if (accept_s) begin
                    s1_data_r <= s1_act_s;
                    s1_last_r <= in_last;
                end
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= s2_dat_s;
                    s2_sat_r  <= s2_sat_s;
                    s2_last_r <= s1_last_r;
                end
            end
        end
    end

`ifdef ACT_QUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_r;
    logic [16:0] sat_sum_s;

    function automatic logic [15:0] popcount(input logic [LANES-1:0] v);
        logic [15:0] cnt;
        cnt = 16'd0;
        for (int i = 0; i < LANES; i++) cnt = cnt + {15'd0, v[i]};
        return cnt;
    endfunction

    assign sat_sum_s = {1'b0, sat_cnt_r} + {1'b0, popcount(s2_sat_r)};
    assign sat_count = sat_cnt_r;

    // Saturating count of clipped lanes in beats leaving the block.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sat_cnt_r <= 16'd0;
        end else if (cfg_take_s) begin
            sat_cnt_r <= 16'd0;
        end else if (fire_s) begin
            sat_cnt_r <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
        end
    end
`else
    logic unused_sat_s;
    assign unused_sat_s = ^s2_sat_r;
    assign sat_count    = 16'h0000;
`endif
endmodule

// File: doc/act_quant_pipe.md
Name: act_quant_pipe

Overview:
Multi-lane, two-stage pipelined activation and requantisation unit that sits between the systolic-array accumulators and the activation buffer.
- Replaces fixed truncate-plus-ReLU with programmable rounding shift, four activation modes and signed saturation.
- Uses valid/ready flow control and tracks layers with a frame state machine.
- The same block serves both the CONV path (LANES=1) and the MUL path (LANES=HEIGHT*WIDTH) by instantiation.

Parameters:
LANES, 8, number of parallel psum lanes per beat
DATA_WIDTH, 8, output activation width (signed)
PSUM_WIDTH, 19, input partial-sum width (signed)
SHIFT_WIDTH, 5, width of the requantisation shift field

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
cfg_load  in  1  load layer configuration (honoured only in IDLE)
cfg_mode  in  2  0=bypass, 1=ReLU, 2=capped ReLU, 3=leaky ReLU
cfg_shift  in  SHIFT_WIDTH  arithmetic right-shift amount (0..PSUM_WIDTH-1)
cfg_cap  in  DATA_WIDTH  upper clamp for mode 2 (treated as unsigned, limited to 2^(DATA_WIDTH-1)-1)
cfg_leak_shift  in  3  negative-slope shift for mode 3
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  LANES*PSUM_WIDTH  packed signed psums; lane i at [i*PSUM_WIDTH +: PSUM_WIDTH]
in_last  in  1  last beat of the layer
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*DATA_WIDTH  packed signed activations
out_last  out  1  last beat of the layer
busy  out  1  state != IDLE
sat_count  out  16  saturation event counter (see optional feature)

Behaviour:
- Reset values: all outputs 0, except in_ready=1. Config registers reset to mode 0, shift 0, cap 0, leak 0. State is IDLE.
- Config capture:
  - When cfg_load=1 in IDLE, all cfg_* fields are registered on that edge.
  - cfg_load outside IDLE is ignored; the config stays stable for the whole layer.
- State machine:
  - IDLE -> RUN on the first accepted beat.
  - RUN -> DRAIN on an accepted beat with in_last=1.
  - DRAIN -> IDLE when the out_last beat transfers (out_valid&out_ready&out_last).
  - An in_last beat accepted in IDLE goes directly IDLE -> DRAIN.
  - in_ready=0 in DRAIN; new layer beats are blocked until the drain completes.
- Pipeline stage S1, per lane:
  - r = (x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. Round half up; add performed at PSUM_WIDTH+1 bits.
  - Activation applied to r:
    - bypass: r unchanged.
    - ReLU: max(r,0).
    - capped ReLU: min(max(r,0), cap).
    - leaky ReLU: r>=0 ? r : r >>> leak_shift.
- Pipeline stage S2:
  - Signed saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - A per-lane saturation flag is raised when clipping occurs.
- Flow control: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv & (state != DRAIN).
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Backpressure: under out_ready=0, out_data, out_last and out_valid are held stable; no beat is lost or duplicated.
- last tag travels with its beat through both stages.
- Simultaneous cfg_load and in_valid in IDLE: the new config is applied to that same beat. Config is muxed combinationally into S1 in that cycle only.
- Async reset mid-layer: both stages are flushed, valids clear, state returns to IDLE, sat_count clears.

Optional Feature:
ACT_QUANT_SAT_CNT_EN
- Defined: sat_count increments by the number of lanes saturated in each beat transferred out. It saturates at 16'hFFFF and clears on cfg_load accepted in IDLE.
- Undefined: no counter logic is built and sat_count is tied to 0.

Test Plan:
1. LANES=8, mode=ReLU, shift=7, lane psums {256,-256,127,128,0,64,-1,191} -> out {2,0,1,1,0,1,0,1} two cycles after acceptance.
2. mode=capped ReLU, cap=6, shift=0, psums {10,5,-3,6,...} -> {6,5,0,6,...}; mode=bypass, psum 300, shift=0 -> 127 with sat flag; psum -300 -> -128.
3. mode=leaky, leak_shift=2, shift=0, psums {-8,-1,12} -> {-2,-1,12}.
4. 10-beat layer with in_last on beat 10, out_ready toggling 1010... -> 10 beats out, in order, data stable while stalled, out_last only on beat 10. busy drops the cycle after that transfer; in_ready stays 0 in DRAIN.
5. cfg_load with mode=ReLU during RUN -> ignored, the layer keeps bypass results. cfg_load in IDLE together with in_valid -> the first beat already uses the new mode.
6. nrst asserted with 2 beats in flight -> out_valid=0 and busy=0 immediately. With the macro defined, sat_count=0, then 3 saturating lanes in one beat -> sat_count=3.
